// File: rtl/code_converter_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_converter_pipe_pkg
//  Description : Shared constants for the Gray/binary conversion pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package code_converter_pipe_pkg;

  // Per-word conversion direction carried alongside the data.
  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  // Width of the output-handshake counter.
  localparam int COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/gray_bin_core.sv
`default_nettype none
// ============================================================================
//  Module      : gray_bin_core
//  Description : Pure combinational Gray<->binary converter, direction chosen
//                per word by mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_bin_core
  import code_converter_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [WIDTH-1:0] result
);

  // Binary bit i of a Gray word is the XOR of all Gray bits at or above i,
  // so a reduction of the shifted word avoids a serial ripple chain.
  always_comb begin
    result = '0;
    if (mode == MODE_B2G) begin
      result = data ^ (data >> 1);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = ^(data >> i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/code_converter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : code_converter_pipe
//  Description : Valid/ready pipelined Gray<->binary converter. Conversion is
//                done ahead of stage 1; remaining stages are retiming
//                registers. Counts completed output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_converter_pipe
  import code_converter_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_mode,
  input  logic               clr_count,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]            conv_result;
  logic [PIPE-1:0]             stage_valid;
  logic [PIPE-1:0]             stage_mode;
  logic [PIPE-1:0][WIDTH-1:0]  stage_data;
  logic [COUNT_W-1:0]          count_q;
  logic [COUNT_W-1:0]          count_d;

  gray_bin_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data   (in_data),
    .mode   (in_mode),
    .result (conv_result)
  );

  // A stage may load when it or any stage after it is empty, or the output
  // is being drained; this is the unrolled form of the per-stage load chain.
  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    logic             src_valid;
    logic             src_mode;
    logic [WIDTH-1:0] src_data;
    logic             load;
    logic             valid_q, valid_d;
    logic             mode_q,  mode_d;
    logic [WIDTH-1:0] data_q,  data_d;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_mode  = in_mode;
      assign src_data  = conv_result;
    end else begin : g_body
      assign src_valid = stage_valid[k-1];
      assign src_mode  = stage_mode[k-1];
      assign src_data  = stage_data[k-1];
    end

    assign load           = out_ready | ~(&stage_valid[PIPE-1:k]);
    assign stage_valid[k] = valid_q;
    assign stage_mode[k]  = mode_q;
    assign stage_data[k]  = data_q;

    // Next stage contents: take the upstream word on load, payload held
    // when nothing valid arrives so outputs do not toggle needlessly.
    always_comb begin
      valid_d = valid_q;
      mode_d  = mode_q;
      data_d  = data_q;
      if (load) begin
        valid_d = src_valid;
        if (src_valid) begin
          mode_d = src_mode;
          data_d = src_data;
        end
      end
    end

    // Stage register with synchronous reset clearing valid and payload.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        mode_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        mode_q  <= mode_d;
        data_q  <= data_d;
      end
    end
  end

  assign in_ready  = ~rst & (out_ready | ~(&stage_valid));
  assign out_valid = stage_valid[PIPE-1];
  assign out_mode  = stage_mode[PIPE-1];
  assign out_data  = stage_data[PIPE-1];
  assign count     = count_q;

  // Handshake counter: clear has priority over increment, wraps naturally.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (out_valid && out_ready) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_converter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_converter_pipe
//  Description : Directed bench for code_converter_pipe: vector table on a
//                PIPE=2 instance, hand sequences for stalls/counter/reset,
//                and a PIPE=1 -> PIPE=4 B2G/G2B round-trip chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_converter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance (WIDTH=8, PIPE=2)
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, clr_count;
  logic [7:0]  in_data, out_data;
  logic [15:0] count;

  code_converter_pipe #(.WIDTH(8), .PIPE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .clr_count(clr_count), .count(count)
  );

  // Round-trip chain: A (PIPE=1, B2G) feeds B (PIPE=4, G2B)
  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_mode, a_clr;
  logic [7:0]  a_in_data, a_out_data;
  logic [15:0] a_count;
  logic        b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_clr;
  logic [7:0]  b_out_data;
  logic [15:0] b_count;

  code_converter_pipe #(.WIDTH(8), .PIPE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(b_in_ready), .out_data(a_out_data), .out_mode(a_out_mode),
    .clr_count(a_clr), .count(a_count)
  );

  code_converter_pipe #(.WIDTH(8), .PIPE(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(a_out_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(a_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
    .clr_count(b_clr), .count(b_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Hand-computed conversions
    vecs[0]  = '{1'b0, 8'hC0, 8'h80};
    vecs[1]  = '{1'b1, 8'hFF, 8'h80};
    vecs[2]  = '{1'b0, 8'h80, 8'hFF};
    vecs[3]  = '{1'b1, 8'h01, 8'h01};
    vecs[4]  = '{1'b1, 8'h02, 8'h03};
    vecs[5]  = '{1'b1, 8'h03, 8'h02};
    vecs[6]  = '{1'b0, 8'hFF, 8'hAA};
    vecs[7]  = '{1'b1, 8'hAA, 8'hFF};
    vecs[8]  = '{1'b1, 8'h55, 8'h7F};
    vecs[9]  = '{1'b0, 8'h40, 8'h7F};
    vecs[10] = '{1'b0, 8'h00, 8'h00};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; clr_count = 1'b0;
    a_in_valid = 1'b0; a_in_mode = 1'b1; a_in_data = 8'h00; a_clr = 1'b0;
    b_in_mode = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_mode", {31'd0, out_mode}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---------------- vector table, one word at a time ----------------
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].dout});
      chk($sformatf("v%0d_mode", i), {31'd0, out_mode}, {31'd0, vecs[i].mode});
      tick();
      chk($sformatf("v%0d_count", i), {16'd0, count}, i + 1);
    end

    // ---------------- back-to-back mixed modes ----------------
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    chk("clr_count", {16'd0, count}, 32'd0);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h80; tick();
    in_mode = 1'b1; in_data = 8'hFF; tick();
    in_valid = 1'b0;
    chk("b2b_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hFF});
    tick();
    chk("b2b_second", {22'd0, out_valid, out_mode, out_data}, {22'd0, 1'b1, 1'b1, 8'h80});
    tick();
    chk("b2b_count", {16'd0, count}, 32'd2);
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- backpressure with full pipeline ----------------
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h03;
    #1;
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});
    tick();
    chk("bp_hold_data", {24'd0, out_data}, 32'h01);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_count", {16'd0, count}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_out2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h03});
    tick();
    chk("bp_out3", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h02});
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_count", {16'd0, count}, 32'd3);

    // ---------------- counter wrap and clear priority ----------------
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      in_data = n[7:0];
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("wrap_preload", {16'd0, count}, 32'hFFFF);
    in_valid = 1'b1; in_data = 8'h5A; tick();
    in_valid = 1'b0; tick(); tick();
    chk("wrap_zero", {16'd0, count}, 32'h0000);
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick();
    chk("clr_coinc_valid", {31'd0, out_valid}, 32'd1);
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    chk("clr_coinc_count", {16'd0, count}, 32'd0);

    // ---------------- reset with words in flight ----------------
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'hC0; tick();
    in_data = 8'h80; tick();
    in_valid = 1'b0;
    chk("inflight_count_pre", {16'd0, count}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_count", {16'd0, count}, 32'd0);
    begin
      int stale = 0;
      for (int n = 0; n < 6; n++) begin
        if (out_valid) stale++;
        tick();
      end
      chk("rst_mid_no_stale", stale, 32'd0);
    end
    chk("rst_mid_count_after", {16'd0, count}, 32'd0);

    // ---------------- round trip through PIPE=1 -> PIPE=4 with stalls ----------------
    begin
      int src_idx = 0;
      int exp_idx = 0;
      int cyc = 0;
      logic src_fire, snk_fire;
      while (exp_idx < 256 && cyc < 4000) begin
        a_in_valid  = (src_idx < 256);
        a_in_data   = src_idx[7:0];
        b_out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        src_fire = a_in_valid && a_in_ready;
        snk_fire = b_out_valid && b_out_ready;
        if (snk_fire) begin
          chk($sformatf("rt_%0d", exp_idx), {23'd0, b_out_mode, b_out_data},
              {23'd0, 1'b0, exp_idx[7:0]});
          exp_idx++;
        end
        @(posedge clk);
        #1;
        if (src_fire) src_idx++;
        cyc++;
      end
      a_in_valid = 1'b0;
      chk("rt_complete", exp_idx, 32'd256);
      tick();
      chk("rt_count_a", {16'd0, a_count}, 32'd256);
      chk("rt_count_b", {16'd0, b_count}, 32'd256);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_converter_pipe.md
CODE_CONVERTER_PIPE -- requirements
Module: code_converter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning code word width in bits (legal 2..32).
REQ-002 SHALL have parameter PIPE, default 2, meaning pipeline depth in register stages (legal 1..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-007 SHALL have port in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray, per word.
REQ-008 SHALL have port in_data  input  WIDTH  word to convert.
REQ-009 SHALL have port out_valid  output  1  converted word present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output word.
REQ-011 SHALL have port out_data  output  WIDTH  converted word.
REQ-012 SHALL have port out_mode  output  1  in_mode that travelled with the word.
REQ-013 SHALL have port clr_count  input  1  synchronous clear of count.
REQ-014 SHALL have port count  output  16  number of output handshakes completed.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 Gray-to-binary SHALL be b[W-1]=g[W-1], b[i]=b[i+1]^g[i] for i = W-2 down to 0 (MSB is index W-1).
REQ-017 Binary-to-Gray SHALL be g[W-1]=b[W-1], g[i]=b[i]^b[i+1].
REQ-018 Conversion SHALL be computed combinationally from in_data/in_mode and captured in stage 1; stages 2..PIPE SHALL be retiming registers carrying data, mode and a valid bit.
REQ-019 Latency from input transfer to out_valid SHALL be exactly PIPE cycles when out_ready is held high.
REQ-020 Stage k SHALL load when it is empty or stage k+1 loads in the same cycle (last stage: when empty or out_ready); in_ready SHALL equal stage 1's load condition.
REQ-021 With out_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-022 With out_ready low and all PIPE stages full, in_ready SHALL be 0 and no word SHALL be lost, duplicated or reordered.
REQ-023 out_data/out_mode SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Words of different mode MAY be interleaved back to back; each SHALL be converted per its own in_mode.
REQ-025 count SHALL increment by 1 on each output transfer and wrap 0xFFFF -> 0x0000.
REQ-026 clr_count SHALL set count to 0 next cycle; if clr_count coincides with an output transfer, count SHALL be 0 (clear wins).

Reset
REQ-027 On rst=1 at a clock edge, all stage valid bits, out_valid and count SHALL become 0; out_data and out_mode SHALL become 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 rst asserted mid-stream SHALL discard all in-flight words; no output transfer SHALL occur in the reset cycle's aftermath until new input arrives.
REQ-030 While rst=1, in_ready SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the mode constants (MODE_G2B=0, MODE_B2G=1) and the count width constant (16).
REQ-032 The pure conversion function SHALL be a sub-module gray_bin_core (combinational, WIDTH-parametrised, inputs data and mode, output result), instantiated once in stage 1.
REQ-033 Pipeline stages SHALL be generated from PIPE; no per-depth hand-written code.

Verification (WIDTH=8, PIPE=2 unless stated)
REQ-034 Mode 0, in_data 0xC0, out_ready=1 -> out_data 0x80, out_mode 0, out_valid exactly 2 cycles after transfer.
REQ-035 Mode 0, in_data 0x80 then mode 1, in_data 0xFF back to back -> outputs 0xFF then 0x80 in consecutive cycles, count=2.
REQ-036 out_ready=0, push 3 words (0x01,0x02,0x03, mode 1) -> only 2 accepted, in_ready=0, out_data held 0x01; release out_ready -> 0x01,0x03,0x02 delivered in order, then third word 0x02 (B2G of 0x03) accepted and delivered.
REQ-037 Exhaustive round trip over all 256 values: B2G output fed back as G2B input -> original value returned; repeat for PIPE=1 and PIPE=4 with random out_ready stalls.
REQ-038 count preloaded by 65535 transfers, one more transfer -> count 0x0000; clr_count coincident with transfer -> count 0.
REQ-039 rst pulsed with 2 words in flight -> out_valid 0 next cycle, count 0, no stale word emitted afterward.
